// File: rtl/bus_slave_sel_pkg.sv
// Shared types and defaults for the latched slave-select decoder.
package bus_slave_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  localparam logic ERR_UNMAPPED = 1'b0;
  localparam logic ERR_TIMEOUT  = 1'b1;

  localparam int unsigned DEF_NUM_SLAVES = 8;
  localparam int unsigned DEF_ADDR_W     = 30;
  localparam int unsigned DEF_IDX_W      = 3;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_TIMEOUT    = 16;
  localparam int unsigned DEF_CNT_W      = 8;

endpackage

// File: rtl/bus_slave_sel_if.sv
// Master-side bus, per-slave selects/returns and error log of the slave-select decoder.
interface bus_slave_sel_if #(
  parameter int unsigned NUM_SLAVES = bus_slave_sel_pkg::DEF_NUM_SLAVES,
  parameter int unsigned ADDR_W     = bus_slave_sel_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W     = bus_slave_sel_pkg::DEF_DATA_W
);
  logic [ADDR_W-1:0]            s_addr;
  logic                         s_as_;
  logic [NUM_SLAVES-1:0]        cs_;
  logic [NUM_SLAVES*DATA_W-1:0] sl_rd_data;
  logic [NUM_SLAVES-1:0]        sl_rdy_;
  logic [DATA_W-1:0]            m_rd_data;
  logic                         m_rdy_;
  logic                         m_err;
  logic                         busy;
  logic                         err_clr;
  logic                         err_valid;
  logic                         err_type;
  logic [ADDR_W-1:0]            err_addr;

  modport slave (
    input  s_addr, s_as_, sl_rd_data, sl_rdy_, err_clr,
    output cs_, m_rd_data, m_rdy_, m_err, busy, err_valid, err_type, err_addr
  );

  modport master (
    output s_addr, s_as_, sl_rd_data, sl_rdy_, err_clr,
    input  cs_, m_rd_data, m_rdy_, m_err, busy, err_valid, err_type, err_addr
  );
endinterface

// File: rtl/bus_slave_sel_watchdog.sv
// Saturating access-cycle counter; flags expiry when the count reaches LIMIT-1 (LIMIT=0 disables).
module bus_slave_sel_watchdog #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset_,
  input  logic clr,
  input  logic inc,
  output logic expired_c
);
  localparam logic [CNT_W-1:0] SAT = (LIMIT == 0) ? {CNT_W{1'b1}} : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_c = (LIMIT != 0) && (cnt_q == SAT);
endmodule

// File: rtl/bus_slave_sel.sv
// Latches the slave index per transaction, drives chip selects, returns the selected
// slave's data/ready, and reports unmapped-index and watchdog errors with a sticky log.
module bus_slave_sel
  import bus_slave_sel_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned IDX_W      = DEF_IDX_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input logic            clk,
  input logic            reset_,
  bus_slave_sel_if.slave bus
);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_valid_q, err_valid_d;
  logic               err_type_q, err_type_d;
  logic [ADDR_W-1:0]  err_addr_q, err_addr_d;

  logic [IDX_W-1:0]      idx_field_c;
  logic [NUM_SLAVES-1:0] hit_c, rdy_hit_c;
  logic [DATA_W-1:0]     data_hit_c [NUM_SLAVES];
  logic [DATA_W-1:0]     sel_data_c;
  logic                  sel_rdy_c;
  logic                  wd_clr_c, wd_inc_c, wd_expired_c;
  logic                  log_err_c, log_type_c;

  assign idx_field_c = bus.s_addr[ADDR_W-1 -: IDX_W];

  // AND-OR mux: only the latched slave, and only while it is ready, reaches the master.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
    assign hit_c[i]      = (idx_q == IDX_W'(i));
    assign rdy_hit_c[i]  = hit_c[i] & ~bus.sl_rdy_[i];
    assign data_hit_c[i] = rdy_hit_c[i] ? bus.sl_rd_data[i*DATA_W +: DATA_W] : '0;
  end

  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) sel_data_c = sel_data_c | data_hit_c[i];
  end

  assign sel_rdy_c = |rdy_hit_c;
  assign wd_clr_c  = (state_q != ST_ACCESS);
  assign wd_inc_c  = (state_q == ST_ACCESS) && !sel_rdy_c;

  bus_slave_sel_watchdog #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset_    (reset_),
    .clr       (wd_clr_c),
    .inc       (wd_inc_c),
    .expired_c (wd_expired_c)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    err_valid_d   = err_valid_q;
    err_type_d    = err_type_q;
    err_addr_d    = err_addr_q;
    log_err_c     = 1'b0;
    log_type_c    = ERR_UNMAPPED;
    bus.cs_       = '1;
    bus.m_rdy_    = 1'b1;
    bus.m_err     = 1'b0;
    bus.m_rd_data = '0;
    bus.busy      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bus.s_as_) begin
          idx_d = idx_field_c;
          if (32'(idx_field_c) < NUM_SLAVES) begin
            state_d = ST_ACCESS;
          end else begin
            state_d   = ST_ERROR;
            log_err_c = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        bus.busy      = 1'b1;
        bus.cs_       = ~hit_c;
        bus.m_rdy_    = ~sel_rdy_c;
        bus.m_rd_data = sel_data_c;
        // Ready takes priority over an expiring watchdog in the same cycle.
        if (sel_rdy_c) begin
          state_d = ST_IDLE;
        end else if (wd_expired_c) begin
          state_d    = ST_ERROR;
          log_err_c  = 1'b1;
          log_type_c = ERR_TIMEOUT;
        end
      end
      ST_ERROR: begin
        bus.busy   = 1'b1;
        bus.m_rdy_ = 1'b0;
        bus.m_err  = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.err_clr) begin
      err_valid_d = 1'b0;
      err_type_d  = 1'b0;
      err_addr_d  = '0;
    end
    // Keep the first error; a clear in the same cycle makes room for the new one.
    if (log_err_c && (!err_valid_q || bus.err_clr)) begin
      err_valid_d = 1'b1;
      err_type_d  = log_type_c;
      err_addr_d  = bus.s_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      err_valid_q <= 1'b0;
      err_type_q  <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_valid_q <= err_valid_d;
      err_type_q  <= err_type_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bus.err_valid = err_valid_q;
  assign bus.err_type  = err_type_q;
  assign bus.err_addr  = err_addr_q;
endmodule

// File: tb/tb_bus_slave_sel.sv
// Table-driven, scoreboarded bench for bus_slave_sel with six slaves.
module tb_bus_slave_sel;
  localparam int unsigned NS = 6;
  localparam int unsigned AW = 30;
  localparam int unsigned IW = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 8;
  localparam int MAX_CYC = 40;

  typedef struct {
    int              idx;
    logic [AW-IW-1:0] low;
    int              rdy_at;
    logic [DW-1:0]   data;
    int              clr_cyc;
    int              exp_lat;
    logic            exp_err;
    logic            exp_type;
  } vec_t;

  typedef struct {
    int            lat;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vt[10];

  logic          mv;
  logic          mt;
  logic [AW-1:0] ma;

  always #5 clk = ~clk;

  bus_slave_sel_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_slave_sel #(
    .NUM_SLAVES (NS),
    .ADDR_W     (AW),
    .IDX_W      (IW),
    .DATA_W     (DW),
    .TIMEOUT    (TO),
    .CNT_W      (CW)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string tag);
    chk({tag, ".err_valid"}, 64'(bus.err_valid), 64'(mv));
    chk({tag, ".err_type"},  64'(bus.err_type),  64'(mt));
    chk({tag, ".err_addr"},  64'(bus.err_addr),  64'(ma));
  endtask

  task automatic run_txn(input vec_t v);
    exp_t          e;
    exp_t          got;
    int            cyc;
    bit            done;
    bit            mapped;
    int            other;
    logic          pre;
    logic [AW-1:0] addr;
    logic [NS-1:0] cs_exp;
    addr   = {IW'(v.idx), v.low};
    mapped = (v.idx < int'(NS));
    e.lat  = v.exp_lat;
    e.err  = v.exp_err;
    e.data = v.exp_err ? '0 : v.data;
    sb.push_back(e);
    bus.s_addr = addr;
    bus.s_as_  = 1'b0;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < MAX_CYC) begin
      bus.err_clr = (cyc == v.clr_cyc);
      for (int i = 0; i < int'(NS); i++) bus.sl_rd_data[i*DW +: DW] = $urandom;
      other = int'($urandom_range(NS - 1, 0));
      bus.sl_rdy_ = '1;
      if (other != v.idx) bus.sl_rdy_[other] = 1'b0;
      if (mapped) begin
        bus.sl_rd_data[v.idx*DW +: DW] = v.data;
        if (cyc == v.rdy_at) bus.sl_rdy_[v.idx] = 1'b0;
      end
      @(negedge clk);
      cs_exp = '1;
      if (mapped && cyc >= 1 && cyc <= v.exp_lat && !(v.exp_err && cyc == v.exp_lat))
        cs_exp[v.idx] = 1'b0;
      chk("cs_", 64'(bus.cs_), 64'(cs_exp));
      chk("busy", 64'(bus.busy), 64'(cyc >= 1 && cyc <= v.exp_lat));
      chk_log("log");
      if (bus.m_rdy_ == 1'b0) begin
        got = sb.pop_front();
        chk("latency",   64'(cyc),           64'(got.lat));
        chk("m_err",     64'(bus.m_err),     64'(got.err));
        chk("m_rd_data", 64'(bus.m_rd_data), 64'(got.data));
        done = 1'b1;
      end else begin
        chk("idle_out", 64'({bus.m_err, bus.m_rd_data}), 64'(0));
      end
      pre = mv;
      if (cyc == v.clr_cyc) begin
        mv = 1'b0; mt = 1'b0; ma = '0;
      end
      if (v.exp_err && cyc == v.exp_lat - 1 && (!pre || cyc == v.clr_cyc)) begin
        mv = 1'b1; mt = v.exp_type; ma = addr;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL txn_done: no m_rdy_ within %0d cycles, idx %0d", MAX_CYC, v.idx);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    bus.s_as_   = 1'b1;
    bus.err_clr = 1'b0;
    bus.sl_rdy_ = '1;
  endtask

  initial begin
    mv = 1'b0; mt = 1'b0; ma = '0;
    bus.s_addr     = '0;
    bus.s_as_      = 1'b1;
    bus.sl_rd_data = '0;
    bus.sl_rdy_    = '1;
    bus.err_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cs_",       64'(bus.cs_),       64'(6'h3F));
    chk("rst.m_rdy_",    64'(bus.m_rdy_),    64'(1));
    chk("rst.m_err",     64'(bus.m_err),     64'(0));
    chk("rst.m_rd_data", 64'(bus.m_rd_data), 64'(0));
    chk("rst.busy",      64'(bus.busy),      64'(0));
    chk_log("rst");
    reset_ = 1'b1;
    @(posedge clk); #1;

    //        idx low        rdy  data           clr lat err type
    vt[0] = '{2, 27'h10,      3,  32'hCAFE_F00D, -1,  3, 1'b0, 1'b0};
    vt[1] = '{7, 27'h55,     -1,  32'h0,         -1,  1, 1'b1, 1'b0};
    vt[2] = '{1, 27'h123,    -1,  32'hDEAD_BEEF, -1, 17, 1'b1, 1'b1};
    vt[3] = '{1, 27'h124,    16,  32'h0A5A_5A5A, -1, 16, 1'b0, 1'b0};
    vt[4] = '{0, 27'h0,       1,  32'h1234_5678, -1,  1, 1'b0, 1'b0};
    vt[5] = '{5, 27'h7FFFFFF, 2,  32'h89AB_CDEF, -1,  2, 1'b0, 1'b0};
    vt[6] = '{6, 27'h66,     -1,  32'h0,          0,  1, 1'b1, 1'b0};
    vt[7] = '{4, 27'h44,     17,  32'h1111_2222, -1, 17, 1'b1, 1'b1};
    vt[8] = '{3, 27'h33,     -1,  32'h0,         16, 17, 1'b1, 1'b1};
    vt[9] = '{2, 27'h2A,      2,  32'h5555_AAAA, -1,  2, 1'b0, 1'b0};

    for (int k = 0; k < 9; k++) run_txn(vt[k]);

    // Reset in the middle of an access: selects drop at once, no completion.
    bus.s_addr = {3'd3, 27'h3};
    bus.s_as_  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid.cs_", 64'(bus.cs_), 64'(6'b110111));
    #2 reset_ = 1'b0;
    #1;
    chk("arst.cs_",      64'(bus.cs_),      64'(6'h3F));
    chk("arst.m_rdy_",   64'(bus.m_rdy_),   64'(1));
    chk("arst.busy",     64'(bus.busy),     64'(0));
    chk("arst.err_valid", 64'(bus.err_valid), 64'(0));
    @(posedge clk); #1;
    chk("arst.m_rdy_2",  64'(bus.m_rdy_),   64'(1));
    reset_    = 1'b1;
    bus.s_as_ = 1'b1;
    mv = 1'b0; mt = 1'b0; ma = '0;
    @(posedge clk); #1;
    run_txn(vt[9]);
    run_txn(vt[1]);

    // Plain clear of a logged error.
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    mv = 1'b0; mt = 1'b0; ma = '0;
    chk_log("clr");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, errors=%0d", n_err);
    $fatal(1);
  end
endmodule
